// File: rtl/fp_op_pkg.sv
// fp_op_pkg: shared types and defaults for the two-operand stb/ack initiator
// and for the benches of the IEEE-754 single-precision arithmetic cores.
package fp_op_pkg;

  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_TIMEOUT = 1000;
  localparam int DEFAULT_CNT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_A = 3'd1,
    ST_SEND_B = 3'd2,
    ST_WAIT_Z = 3'd3,
    ST_ACK_Z  = 3'd4,
    ST_RESULT = 3'd5
  } fp_op_state_t;

endpackage

// File: rtl/fp_op_timer.sv
// fp_op_timer: per-transaction cycle counter. Clears on request, counts while
// enabled, and flags expiry when the count reaches LIMIT.
module fp_op_timer #(
  parameter int CNT_W = 16,
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q;

  // Count cycles spent waiting on the core; restart on every state change.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process evaluation order.
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/fp_op_initiator.sv
// fp_op_initiator: takes operand pairs from a valid/ready stream, presents A
// then B to an arithmetic core over stb/ack, collects Z and returns it on a
// valid/ready result stream. All outputs are registered.
// Optional feature macro FP_OP_INITIATOR_TIMEOUT_EN: aborts a transaction
// stuck in SEND_A/SEND_B/WAIT_Z after TIMEOUT_CYCLES and reports it through
// res_err and the sticky timeout flag. Without it both are tied low.
module fp_op_initiator
  import fp_op_pkg::*;
#(
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_z,
  output logic              res_err,
  output logic [DATA_W-1:0] core_a,
  output logic              core_a_stb,
  input  logic              core_a_ack,
  output logic [DATA_W-1:0] core_b,
  output logic              core_b_stb,
  input  logic              core_b_ack,
  input  logic [DATA_W-1:0] core_z,
  input  logic              core_z_stb,
  output logic              core_z_ack,
  output logic              busy,
  output logic              timeout
);

  // The counter must be wide enough to reach the abort threshold.
  if (CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_cnt_w_check
    $error("fp_op_initiator: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  fp_op_state_t      state_q, state_d;
  logic [DATA_W-1:0] core_a_q, core_a_d;
  logic [DATA_W-1:0] core_b_q, core_b_d;
  logic [DATA_W-1:0] res_z_q, res_z_d;
  logic              a_stb_q, a_stb_d;
  logic              b_stb_q, b_stb_d;
  logic              z_ack_q, z_ack_d;
  logic              res_valid_q, res_valid_d;
  logic              op_ready_q, op_ready_d;
  logic              busy_q, busy_d;

`ifdef FP_OP_INITIATOR_TIMEOUT_EN
  logic expired;
  logic counting;
  logic res_err_q, res_err_d;
  logic timeout_q, timeout_d;

  assign counting = (state_q == ST_SEND_A) || (state_q == ST_SEND_B) ||
                    (state_q == ST_WAIT_Z);

  fp_op_timer #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_d != state_q),
    .enable (counting),
    .expire (expired)
  );
`endif

  // Next-state and next-output logic for the handshake sequencer.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    core_a_d    = core_a_q;
    core_b_d    = core_b_q;
    res_z_d     = res_z_q;
    a_stb_d     = a_stb_q;
    b_stb_d     = b_stb_q;
    z_ack_d     = z_ack_q;
    res_valid_d = res_valid_q;
`ifdef FP_OP_INITIATOR_TIMEOUT_EN
    res_err_d   = res_err_q;
    timeout_d   = timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (op_valid && op_ready_q) begin
          core_a_d = op_a;
          core_b_d = op_b;
          a_stb_d  = 1'b1;
          state_d  = ST_SEND_A;
        end
      end
      ST_SEND_A: begin
        if (a_stb_q && core_a_ack) begin
          a_stb_d = 1'b0;
          b_stb_d = 1'b1;
          state_d = ST_SEND_B;
        end
      end
      ST_SEND_B: begin
        if (b_stb_q && core_b_ack) begin
          b_stb_d = 1'b0;
          state_d = ST_WAIT_Z;
        end
      end
      ST_WAIT_Z: begin
        if (core_z_stb) begin
          res_z_d = core_z;
          z_ack_d = 1'b1;
          state_d = ST_ACK_Z;
        end
      end
      ST_ACK_Z: begin
        z_ack_d     = 1'b0;
        res_valid_d = 1'b1;
`ifdef FP_OP_INITIATOR_TIMEOUT_EN
        res_err_d   = 1'b0;
`endif
        state_d     = ST_RESULT;
      end
      ST_RESULT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
`ifdef FP_OP_INITIATOR_TIMEOUT_EN
          res_err_d   = 1'b0;
`endif
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef FP_OP_INITIATOR_TIMEOUT_EN
    // Abort overrides any handshake progress made in the same cycle.
    if (counting && expired) begin
      a_stb_d     = 1'b0;
      b_stb_d     = 1'b0;
      z_ack_d     = 1'b0;
      res_z_d     = '0;
      res_err_d   = 1'b1;
      res_valid_d = 1'b1;
      timeout_d   = 1'b1;
      state_d     = ST_RESULT;
    end
`endif

    op_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers; reset also clears captured operands/result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      core_a_q    <= '0;
      core_b_q    <= '0;
      res_z_q     <= '0;
      a_stb_q     <= 1'b0;
      b_stb_q     <= 1'b0;
      z_ack_q     <= 1'b0;
      res_valid_q <= 1'b0;
      op_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      core_a_q    <= core_a_d;
      core_b_q    <= core_b_d;
      res_z_q     <= res_z_d;
      a_stb_q     <= a_stb_d;
      b_stb_q     <= b_stb_d;
      z_ack_q     <= z_ack_d;
      res_valid_q <= res_valid_d;
      op_ready_q  <= op_ready_d;
      busy_q      <= busy_d;
    end
  end

`ifdef FP_OP_INITIATOR_TIMEOUT_EN
  // Abort status: res_err qualifies the current result, timeout is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      res_err_q <= res_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign res_err = res_err_q;
  assign timeout = timeout_q;
`else
  assign res_err = 1'b0;
  assign timeout = 1'b0;
`endif

  assign op_ready   = op_ready_q;
  assign res_valid  = res_valid_q;
  assign res_z      = res_z_q;
  assign core_a     = core_a_q;
  assign core_a_stb = a_stb_q;
  assign core_b     = core_b_q;
  assign core_b_stb = b_stb_q;
  assign core_z_ack = z_ack_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fp_op_initiator.sv
// tb_fp_op_initiator: scoreboard bench for fp_op_initiator. A behavioural
// core responder answers the stb/ack handshake with programmable delays; the
// expected result of every accepted operand pair is queued at issue time and
// a monitor compares it when the result handshake happens.
module tb_fp_op_initiator;

  localparam int TO = 1000;

  typedef struct {
    logic [31:0] z;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [31:0] op_a = '0, op_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_z;
  logic        res_err;
  logic [31:0] core_a, core_b, core_z;
  logic        core_a_stb, core_b_stb, core_z_ack;
  logic        core_a_ack, core_b_ack, core_z_stb;
  logic        busy, timeout;

  int   n_checks = 0, n_fail = 0;
  int   n_expect = 0, n_results = 0;
  int   viol_overlap = 0, viol_stable = 0, viol_zack = 0, viol_ready = 0;
  exp_t exp_q[$];
  int   da = 0, db = 0, dz = 0;
  int   resp_ph = 0;
  bit   spur = 1'b0;
  bit   rr_mode = 1'b1;
  logic rr_val = 1'b1;

  fp_op_initiator #(.DATA_W(32), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z), .res_err(res_err),
    .core_a(core_a), .core_a_stb(core_a_stb), .core_a_ack(core_a_ack),
    .core_b(core_b), .core_b_stb(core_b_stb), .core_b_ack(core_b_ack),
    .core_z(core_z), .core_z_stb(core_z_stb), .core_z_ack(core_z_ack),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Stand-in for the arithmetic core: known IEEE-754 products (NaN as the
  // multiplier emits it) for the directed pairs, an arbitrary mix otherwise.
  // The initiator is data-transparent, so any function works.
  function automatic logic [31:0] model_core(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3f800000 && b == 32'h40000000) return 32'h40000000;
    if (a == 32'h40400000 && b == 32'h40400000) return 32'h41100000;
    if (a == 32'h7fc00000 && b == 32'h3f800000) return 32'hffc00000;
    if (a == 32'h00000000 && b == 32'hff800000) return 32'hffc00000;
    if (a == 32'h3f800000 && b == 32'h3f800000) return 32'h3f800000;
    return (a ^ {b[15:0], b[31:16]}) + 32'h9e3779b9;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one operand pair and wait (bounded) for it to be accepted.
  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic err);
    logic acc;
    int   waited;
    exp_q.push_back('{z: err ? 32'h0 : model_core(a, b), err: err});
    n_expect++;
    op_a = a; op_b = b; op_valid = 1'b1;
    waited = 0;
    do begin
      @(posedge clk);
      acc = op_ready;
      #1;
      waited++;
    end while (!acc && waited < 3000);
    if (!acc) check("op_accept_timeout", 32'(acc), 32'd1);
    op_valid = 1'b0;
  endtask

  // Wait (bounded) until every queued result has been delivered.
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy || res_valid) && n < 3000);
    if (n >= 3000) check("wait_idle_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // res_ready driver: random backpressure unless the test forces a value.
  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #2;
      res_ready = rr_mode ? rr_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Behavioural core: acks A and B after da/db stb cycles, presents Z dz
  // cycles later and holds it until acked. Optionally emits stray z_stb
  // pulses while no result is due.
  initial begin : responder
    int          cnt;
    logic        s_rst, sa, sb, szack;
    logic [31:0] ra, rb, ca, cb;
    cnt = 0; ca = '0; cb = '0;
    core_a_ack = 1'b0; core_b_ack = 1'b0; core_z_stb = 1'b0; core_z = '0;
    forever begin
      @(posedge clk);
      s_rst = rst; sa = core_a_stb; sb = core_b_stb; szack = core_z_ack;
      ra = core_a; rb = core_b;
      #1;
      if (s_rst) begin
        resp_ph = 0; cnt = 0;
        core_a_ack = 1'b0; core_b_ack = 1'b0; core_z_stb = 1'b0;
      end else begin
        case (resp_ph)
          0: begin
            core_z_stb = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            core_z     = $urandom;
            if (!sa) begin
              cnt = 0; core_a_ack = 1'b0;
            end else if (core_a_ack) begin
              ca = ra; core_a_ack = 1'b0; cnt = 0; resp_ph = 1;
            end else if (cnt >= da) core_a_ack = 1'b1;
            else cnt++;
          end
          1: begin
            core_z_stb = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            core_z     = $urandom;
            if (!sb) begin
              cnt = 0; core_b_ack = 1'b0;
            end else if (core_b_ack) begin
              cb = rb; core_b_ack = 1'b0; cnt = 0; core_z_stb = 1'b0; resp_ph = 2;
            end else if (cnt >= db) core_b_ack = 1'b1;
            else cnt++;
          end
          2: begin
            if (cnt >= dz) begin
              core_z = model_core(ca, cb); core_z_stb = 1'b1; resp_ph = 3;
            end else cnt++;
          end
          default: begin
            if (szack) begin
              core_z_stb = 1'b0; cnt = 0; resp_ph = 0;
            end
          end
        endcase
      end
    end
  end

  // Monitor: protocol invariants every cycle, scoreboard on each result
  // handshake, and op_ready one cycle after that handshake.
  initial begin : monitor
    bit          chk_ready;
    logic        pa_stb, pb_stb, pzack;
    logic [31:0] pa, pb;
    exp_t        e;
    chk_ready = 1'b0; pa_stb = 1'b0; pb_stb = 1'b0; pzack = 1'b0; pa = '0; pb = '0;
    forever begin
      @(negedge clk);
      if (chk_ready) begin
        check("op_ready_after_handshake", 32'(op_ready), 32'd1);
        chk_ready = 1'b0;
      end
      if (!rst) begin
        if (core_a_stb && core_b_stb) viol_overlap++;
        if ((pa_stb && core_a_stb && core_a != pa) ||
            (pb_stb && core_b_stb && core_b != pb)) viol_stable++;
        if (pzack && core_z_ack) viol_zack++;
        if (op_ready == busy) viol_ready++;
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 32'(res_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("res_z", res_z, e.z);
            check("res_err", 32'(res_err), 32'(e.err));
            n_results++;
            chk_ready = 1'b1;
          end
        end
      end
      pa_stb = core_a_stb; pb_stb = core_b_stb; pzack = core_z_ack;
      pa = core_a; pb = core_b;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] z0, ra, rb, specials[6];
    logic        acc;
    int          n, lat;
    specials[0] = 32'h00000000; specials[1] = 32'h80000000;
    specials[2] = 32'h7f800000; specials[3] = 32'hff800000;
    specials[4] = 32'h7fc00000; specials[5] = 32'h7fa00001;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_op_ready", 32'(op_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);
    check("rst_res_z", res_z, 32'h0);
    check("rst_strobes", {29'd0, core_a_stb, core_b_stb, core_z_ack}, 32'd0);
    check("rst_core_a", core_a, 32'h0);
    check("rst_core_b", core_b, 32'h0);
    check("rst_busy_timeout", {30'd0, busy, timeout}, 32'd0);
    @(posedge clk); #1;

    // Zero-wait core: 1.0 * 2.0.
    da = 0; db = 0; dz = 0; rr_mode = 1'b1; rr_val = 1'b1;
    send_op(32'h3f800000, 32'h40000000, 1'b0);
    wait_idle();

    // Slow core: 3.0 * 3.0.
    da = 4; db = 7; dz = 10;
    send_op(32'h40400000, 32'h40400000, 1'b0);
    wait_idle();

    // Backpressure: result held 5 cycles, a waiting op must not be taken.
    da = 1; db = 1; dz = 1; rr_val = 1'b0;
    send_op(32'h40000000, 32'h3f800000, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 200);
    check("stall_res_valid_seen", 32'(res_valid), 32'd1);
    z0 = res_z;
    @(posedge clk); #1;
    exp_q.push_back('{z: model_core(32'h12345678, 32'h9abcdef0), err: 1'b0});
    n_expect++;
    op_a = 32'h12345678; op_b = 32'h9abcdef0; op_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_res_valid", 32'(res_valid), 32'd1);
      check("stall_res_z", res_z, z0);
      check("stall_op_ready", 32'(op_ready), 32'd0);
      check("stall_no_new_a_stb", 32'(core_a_stb), 32'd0);
    end
    @(posedge clk); #1 rr_val = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      acc = op_ready;
      #1;
      lat++;
    end while (!acc && lat < 100);
    check("stall_accept_latency", 32'(lat), 32'd2);
    op_valid = 1'b0;
    wait_idle();

    // Back-to-back NaN-producing pairs.
    da = 0; db = 0; dz = 2;
    send_op(32'h7fc00000, 32'h3f800000, 1'b0);
    send_op(32'h00000000, 32'hff800000, 1'b0);
    wait_idle();

    // Randomised traffic with random delays, backpressure and stray z_stb.
    rr_mode = 1'b0; spur = 1'b1;
    for (int i = 0; i < 30; i++) begin
      da = $urandom_range(0, 4); db = $urandom_range(0, 4); dz = $urandom_range(0, 6);
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      send_op(ra, rb, 1'b0);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    wait_idle();
    rr_mode = 1'b1; rr_val = 1'b1; spur = 1'b0;

`ifdef FP_OP_INITIATOR_TIMEOUT_EN
    // Core never acks A: abort after the counter reaches TO in SEND_A.
    da = 1_000_000;
    send_op(32'h3f800000, 32'h40000000, 1'b1);
    n = 0; lat = 0;
    do begin
      @(negedge clk);
      if (core_a_stb) lat++;
      n++;
    end while (!res_valid && n < TO + 100);
    check("to_a_stb_cycles", 32'(lat), 32'(TO + 1));
    check("to_res_valid", 32'(res_valid), 32'd1);
    check("to_core_a_stb", 32'(core_a_stb), 32'd0);
    check("to_res_err", 32'(res_err), 32'd1);
    check("to_timeout", 32'(timeout), 32'd1);
    check("to_res_z", res_z, 32'h0);
    @(posedge clk); #1;
    da = 2;
    send_op(32'h40400000, 32'h40400000, 1'b0);
    wait_idle();
    check("to_sticky", 32'(timeout), 32'd1);
`endif

    // Reset while waiting for Z: everything returns to reset values.
    da = 0; db = 0; dz = 40;
    send_op(32'h3f800000, 32'h40000000, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (resp_ph != 2 && n < 100);
    check("mid_reached_wait_z", 32'(resp_ph), 32'd2);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    n_expect--;
    @(negedge clk);
    check("mid_rst_op_ready", 32'(op_ready), 32'd1);
    check("mid_rst_res", {30'd0, res_valid, res_err}, 32'd0);
    check("mid_rst_res_z", res_z, 32'h0);
    check("mid_rst_strobes", {29'd0, core_a_stb, core_b_stb, core_z_ack}, 32'd0);
    check("mid_rst_core_a", core_a, 32'h0);
    check("mid_rst_core_b", core_b, 32'h0);
    check("mid_rst_busy_timeout", {30'd0, busy, timeout}, 32'd0);
    @(posedge clk); #1;
    dz = 1;
    send_op(32'h3f800000, 32'h3f800000, 1'b0);
    wait_idle();

    check("result_count", 32'(n_results), 32'(n_expect));
    check("no_stb_overlap", 32'(viol_overlap), 32'd0);
    check("operands_stable", 32'(viol_stable), 32'd0);
    check("z_ack_single_cycle", 32'(viol_zack), 32'd0);
    check("op_ready_vs_busy", 32'(viol_ready), 32'd0);
    check("final_timeout", 32'(timeout), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_op_initiator.md
Name: fp_op_initiator

Overview:
- Synthesizable initiator for the two-operand stb/ack protocol used by the IEEE-754 single-precision arithmetic cores (multiplier and siblings).
- Accepts operand pairs from an upstream valid/ready stream and presents A, then B, to the core.
- Collects output Z and returns it downstream on a valid/ready stream.
- Replaces bench-only driving code so the arithmetic cores can be used inside a datapath.

Parameters:
- DATA_W, 32, operand/result width in bits.
- TIMEOUT_CYCLES, 1000, cycles allowed per transaction before abort (used only with the timeout feature).
- CNT_W, 16, width of the internal timeout counter; must be able to hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op_valid  in  1  upstream operand pair valid
- op_ready  out  1  initiator can accept an operand pair
- op_a  in  DATA_W  operand A
- op_b  in  DATA_W  operand B
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result
- res_z  out  DATA_W  result
- res_err  out  1  result aborted by timeout (qualifies res_valid)
- core_a  out  DATA_W  to core input_a
- core_a_stb  out  1  to core input_a_stb
- core_a_ack  in  1  from core input_a_ack
- core_b  out  DATA_W  to core input_b
- core_b_stb  out  1  to core input_b_stb
- core_b_ack  in  1  from core input_b_ack
- core_z  in  DATA_W  from core output_z
- core_z_stb  in  1  from core output_z_stb
- core_z_ack  out  1  to core output_z_ack
- busy  out  1  state is not IDLE
- timeout  out  1  sticky: a timeout has occurred since reset

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- On reset:
  - state=IDLE; op_ready=1; res_valid=0, res_err=0, res_z=0.
  - All core_*_stb=0, core_z_ack=0, core_a=core_b=0.
  - busy=0, timeout=0; counter=0.
- All outputs are registered.
- FSM states: IDLE, SEND_A, SEND_B, WAIT_Z, ACK_Z, RESULT.
  - IDLE: op_ready=1. On op_valid&op_ready, latch op_a/op_b into core_a/core_b, set core_a_stb=1 next cycle, go to SEND_A.
  - SEND_A: hold core_a_stb=1 and core_a stable. When core_a_ack is sampled 1, next cycle core_a_stb=0 and core_b_stb=1; go to SEND_B.
  - SEND_B: same rule with core_b_ack. Then core_b_stb=0; go to WAIT_Z.
  - WAIT_Z: when core_z_stb is sampled 1, capture core_z into res_z, drive core_z_ack=1 for exactly one cycle, go to ACK_Z.
  - ACK_Z: core_z_ack=0, res_valid=1, res_err=0; go to RESULT.
  - RESULT: hold res_valid, res_z and res_err until res_valid&res_ready. Next cycle res_valid=0 and state=IDLE.
- op_ready=0 in every state except IDLE; there is no operand buffering.
- Minimum latency with a zero-wait core, from op accept to res_valid, is 3 cycles plus core compute time.
- Back-to-back: the next op can be accepted the cycle after the result handshake completes.
- Never drive a_stb and b_stb high in the same cycle. core_a/core_b stay unchanged while their stb is high.
- An ack arriving while its stb is low is ignored. A core_z_stb arriving outside WAIT_Z is ignored.
- Reset mid-transaction: all strobes and acks drop on the next edge and captured operands are discarded. The system resets the core in the same cycle.
- Result data passes through unmodified; NaN payloads are not canonicalised.

Optional Feature:
- Macro FP_OP_INITIATOR_TIMEOUT_EN.
- With the macro:
  - The counter increments each cycle in SEND_A, SEND_B and WAIT_Z, and clears on any state change.
  - When counter==TIMEOUT_CYCLES: next cycle all core strobes=0, res_z=0, res_err=1, res_valid=1, timeout=1 (sticky until reset); go to RESULT.
- Without the macro:
  - No counter is built; the FSM waits indefinitely.
  - timeout and res_err are tied to 0.

Decomposition:
- Package fp_op_pkg:
  - state enum fp_op_state_t.
  - DATA_W default constant.
  - DEFAULT_TIMEOUT=1000.
  - Shared by the arithmetic cores' testbenches.
- Sub-module fp_op_timer: counter with clear/enable/expire. Instantiated only under FP_OP_INITIATOR_TIMEOUT_EN.

Test Plan:
- Multiplier core attached; op_a=3f800000, op_b=40000000, res_ready=1 → res_z=40000000, res_err=0, one res_valid pulse, busy back to 0.
- Behavioural responder delays a_ack 4 cycles, b_ack 7 cycles, z_stb 10 cycles; op 40400000 × 40400000 → res_z=41100000, core_a_stb never overlaps core_b_stb, core_z_ack high exactly 1 cycle.
- res_ready held 0 for 5 cycles after res_valid → res_valid and res_z stable, op_ready=0, a new op_valid is not accepted until the handshake completes.
- Two back-to-back ops (7fc00000×3f800000, then 00000000×ff800000) → results delivered in order, each a NaN per core, op_ready reasserted 1 cycle after each result handshake.
- With FP_OP_INITIATOR_TIMEOUT_EN, responder never asserts a_ack → at cycle 1000 in SEND_A: core_a_stb=0, res_valid=1, res_err=1, timeout=1; the next op then completes normally with timeout still 1.
- rst asserted for 1 cycle while in WAIT_Z → all outputs return to reset values next edge; a subsequent op 3f800000×3f800000 yields 3f800000.
